// File: rtl/stage_execute_pkg.sv
// Shared pipeline types for the execute stage.
// Holds the ID-EX and EX-MEM register layouts, the one-hot ALU function bit
// indices, the execute FSM state encoding and the shift helper used by both the
// inline ALU and the serial shifter.
package stage_execute_pkg;

  localparam int XLEN      = 32;
  localparam int ALU_FUN_W = 11;

  // Bit positions inside the one-hot alu_fun vector
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_SLL   = 2;
  localparam int ALU_SLT   = 3;
  localparam int ALU_SLTU  = 4;
  localparam int ALU_XOR   = 5;
  localparam int ALU_SRL   = 6;
  localparam int ALU_SRA   = 7;
  localparam int ALU_OR    = 8;
  localparam int ALU_AND   = 9;
  localparam int ALU_COPY1 = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ex_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_op_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc_plus_four;
    logic [2:0]           func3;
    logic [XLEN-1:0]      dmem_data;
    logic                 dmem_rd_en;
    logic                 dmem_wr_en;
    logic                 reg_wr_en;
    logic [1:0]           reg_wr_sel;
    logic [4:0]           reg_wr_addr;
    logic [ALU_FUN_W-1:0] alu_fun;
    logic [XLEN-1:0]      alu_op1;
    logic [XLEN-1:0]      alu_op2;
  } id_ex_reg_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc_plus_four;
    logic [2:0]      func3;
    logic [XLEN-1:0] dmem_data;
    logic            dmem_rd_en;
    logic            dmem_wr_en;
    logic            reg_wr_en;
    logic [1:0]      reg_wr_sel;
    logic [4:0]      reg_wr_addr;
    logic [XLEN-1:0] alu_result;
  } ex_mem_reg_t;

  // Shift by amt; SRA fills vacated bits with the supplied sign so that a
  // multi-step shift keeps using the sign of the original operand.
  function automatic logic [XLEN-1:0] shift_fill(input logic [XLEN-1:0] data,
                                                 input logic [4:0]      amt,
                                                 input shift_op_e       op,
                                                 input logic            sign);
    logic [XLEN-1:0] res;
    case (op)
      SH_SLL:  res = data << amt;
      SH_SRL:  res = data >> amt;
      SH_SRA:  res = (data >> amt) | ({XLEN{sign}} & ~({XLEN{1'b1}} >> amt));
      default: res = data;
    endcase
    return res;
  endfunction

  // Build an EX-MEM entry. A non-live entry is a bubble: it carries the
  // bookkeeping fields but can never write memory or the register file.
  function automatic ex_mem_reg_t ex_mem_from(input id_ex_reg_t      id,
                                              input logic [XLEN-1:0] result,
                                              input logic            live);
    ex_mem_reg_t e;
    e.valid        = live & id.valid;
    e.pc_plus_four = id.pc_plus_four;
    e.func3        = id.func3;
    e.dmem_data    = id.dmem_data;
    e.dmem_rd_en   = live & id.dmem_rd_en;
    e.dmem_wr_en   = live & id.dmem_wr_en;
    e.reg_wr_en    = live & id.reg_wr_en;
    e.reg_wr_sel   = id.reg_wr_sel;
    e.reg_wr_addr  = id.reg_wr_addr;
    e.alu_result   = live ? result : '0;
    return e;
  endfunction

endpackage

// File: rtl/stage_execute_serial.sv
// serial_shifter: iterative shifter datapath for long shifts.
// Ports:
//   clk, rst_ni          - clock, asynchronous active-low reset
//   start_i              - latch operand/op/count and perform the first step
//   step_i               - perform one intermediate step of SHIFT_STEP bits
//   clear_i              - discard any shift in progress
//   op_i, operand_i,
//   shamt_i              - shift request (only sampled on start_i)
//   done_o               - remaining count fits in one step (final cycle)
//   result_o             - value after the final step (valid while done_o)
module serial_shifter
  import stage_execute_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            clear_i,
  input  shift_op_e       op_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic [4:0]      shamt_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [XLEN-1:0] data_reg, data_next;
  logic [4:0]      remain_reg, remain_next;
  shift_op_e       op_reg, op_next;
  logic            sign_reg, sign_next;

  always_comb begin
    data_next   = data_reg;
    remain_next = remain_reg;
    op_next     = op_reg;
    sign_next   = sign_reg;
    if (clear_i) begin
      data_next   = '0;
      remain_next = '0;
      op_next     = SH_SLL;
      sign_next   = 1'b0;
    end else if (start_i) begin
      // The start cycle already counts as one step of the shift.
      data_next   = shift_fill(operand_i, STEP, op_i, operand_i[XLEN-1]);
      remain_next = shamt_i - STEP;
      op_next     = op_i;
      sign_next   = operand_i[XLEN-1];
    end else if (step_i) begin
      data_next   = shift_fill(data_reg, STEP, op_reg, sign_reg);
      remain_next = remain_reg - STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      data_reg   <= '0;
      remain_reg <= '0;
      op_reg     <= SH_SLL;
      sign_reg   <= 1'b0;
    end else begin
      data_reg   <= data_next;
      remain_reg <= remain_next;
      op_reg     <= op_next;
      sign_reg   <= sign_next;
    end
  end

  // Final step shifts by whatever is left, which is at most SHIFT_STEP.
  assign done_o   = (remain_reg <= STEP);
  assign result_o = shift_fill(data_reg, remain_reg, op_reg, sign_reg);

endmodule

// File: rtl/stage_execute.sv
// stage_execute: execute pipeline stage with an inline single-cycle ALU and
// a serial shifter for shifts longer than SHIFT_STEP bits.
// Ports:
//   clk, rst_ni   - clock, asynchronous active-low reset
//   stall_i       - downstream stall: hold EX-MEM register and FSM
//   squash_i      - kill the instruction in EX (beats stall_i)
//   id_ex_i       - ID-EX pipeline register contents
//   ex_mem_reg_o  - registered EX-MEM pipeline register
//   busy_o        - combinational; upstream must hold id_ex_i while high
module stage_execute
  import stage_execute_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        squash_i,
  input  id_ex_reg_t  id_ex_i,
  output ex_mem_reg_t ex_mem_reg_o,
  output logic        busy_o
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  ex_state_e       state_reg, state_next;
  ex_mem_reg_t     ex_mem_reg, ex_mem_next;
  logic            ex_mem_load;
  logic [XLEN-1:0] op1, op2, alu_result, shift_result;
  logic [4:0]      shamt;
  logic            is_shift, long_shift, shift_done;
  logic            shift_start, shift_step, shift_clear, busy_raw;
  shift_op_e       shift_op;

  assign op1        = id_ex_i.alu_op1;
  assign op2        = id_ex_i.alu_op2;
  assign shamt      = op2[4:0];
  assign is_shift   = id_ex_i.alu_fun[ALU_SLL] | id_ex_i.alu_fun[ALU_SRL] |
                      id_ex_i.alu_fun[ALU_SRA];
  assign shift_op   = id_ex_i.alu_fun[ALU_SRA] ? SH_SRA :
                      id_ex_i.alu_fun[ALU_SRL] ? SH_SRL : SH_SLL;
  // Shifts that fit into one step never enter the serial shifter.
  assign long_shift = id_ex_i.valid & is_shift & (shamt > STEP);

  // Inline ALU; the shift branch only matters for short shifts.
  always_comb begin
    alu_result = '0;
    if (id_ex_i.alu_fun[ALU_ADD])        alu_result = op1 + op2;
    else if (id_ex_i.alu_fun[ALU_SUB])   alu_result = op1 - op2;
    else if (id_ex_i.alu_fun[ALU_SLT])   alu_result = {31'b0, $signed(op1) < $signed(op2)};
    else if (id_ex_i.alu_fun[ALU_SLTU])  alu_result = {31'b0, op1 < op2};
    else if (id_ex_i.alu_fun[ALU_XOR])   alu_result = op1 ^ op2;
    else if (id_ex_i.alu_fun[ALU_OR])    alu_result = op1 | op2;
    else if (id_ex_i.alu_fun[ALU_AND])   alu_result = op1 & op2;
    else if (id_ex_i.alu_fun[ALU_COPY1]) alu_result = op1;
    else if (is_shift)                   alu_result = shift_fill(op1, shamt, shift_op, op1[XLEN-1]);
  end

  serial_shifter #(
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .start_i   (shift_start),
    .step_i    (shift_step),
    .clear_i   (shift_clear),
    .op_i      (shift_op),
    .operand_i (op1),
    .shamt_i   (shamt),
    .done_o    (shift_done),
    .result_o  (shift_result)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    if (squash_i) begin
      state_next = ST_IDLE;
    end else if (!stall_i) begin
      case (state_reg)
        ST_IDLE:  if (long_shift) state_next = ST_SHIFT;
        ST_SHIFT: if (shift_done) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs. While a long shift is in progress EX-MEM receives bubbles so
  // the previous instruction is not seen twice downstream.
  always_comb begin
    busy_raw    = 1'b0;
    shift_start = 1'b0;
    shift_step  = 1'b0;
    shift_clear = 1'b0;
    ex_mem_load = 1'b0;
    ex_mem_next = ex_mem_from(id_ex_i, '0, 1'b0);
    if (squash_i) begin
      shift_clear = 1'b1;
      ex_mem_load = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          busy_raw    = long_shift & ~stall_i;
          shift_start = long_shift & ~stall_i;
          ex_mem_load = ~stall_i;
          if (!long_shift) ex_mem_next = ex_mem_from(id_ex_i, alu_result, 1'b1);
        end
        ST_SHIFT: begin
          busy_raw    = ~shift_done;
          shift_step  = ~shift_done & ~stall_i;
          ex_mem_load = ~stall_i;
          if (shift_done) ex_mem_next = ex_mem_from(id_ex_i, shift_result, 1'b1);
        end
        default: ;
      endcase
    end
  end

  // busy must read low for the whole time reset is held.
  assign busy_o = busy_raw & rst_ni;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)          ex_mem_reg <= '0;
    else if (ex_mem_load) ex_mem_reg <= ex_mem_next;
  end

  assign ex_mem_reg_o = ex_mem_reg;

endmodule

// File: tb/tb_stage_execute.sv
// Directed testbench for stage_execute: one instance with SHIFT_STEP=1 and one
// with SHIFT_STEP=4, sharing stimulus; use4 selects which one sees valid ops.
module tb_stage_execute;
  import stage_execute_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        stall = 1'b0;
  logic        squash = 1'b0;
  logic        use4 = 1'b0;
  id_ex_reg_t  id, id1, id4;
  ex_mem_reg_t ex1, ex4;
  logic        busy1, busy4;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    id1       = id;
    id1.valid = id.valid & ~use4;
    id4       = id;
    id4.valid = id.valid & use4;
  end

  stage_execute #(.SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst_ni(rst_ni), .stall_i(stall), .squash_i(squash),
    .id_ex_i(id1), .ex_mem_reg_o(ex1), .busy_o(busy1)
  );

  stage_execute #(.SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst_ni(rst_ni), .stall_i(stall), .squash_i(squash),
    .id_ex_i(id4), .ex_mem_reg_o(ex4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int fbit, input logic [31:0] a, input logic [31:0] b, input logic wr);
    id              = '0;
    id.valid        = 1'b1;
    id.pc_plus_four = 32'h0000_1004;
    id.func3        = 3'd2;
    id.dmem_data    = 32'hCAFE_F00D;
    id.dmem_wr_en   = wr;
    id.reg_wr_en    = 1'b1;
    id.reg_wr_sel   = 2'd1;
    id.reg_wr_addr  = 5'd7;
    id.alu_fun      = 11'(1) << fbit;
    id.alu_op1      = a;
    id.alu_op2      = b;
  endtask

  // Hold the presented shift until the selected DUT loads a valid result.
  task automatic run_until_load(input bit sel4, input int stall_from, input int stall_n,
                                output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      stall = (c >= stall_from) && (c < stall_from + stall_n);
      #1;
      if (sel4 ? busy4 : busy1) busy_cnt++;
      tick();
      edges++;
      if (sel4 ? ex4.valid : ex1.valid) break;
    end
    stall = 1'b0;
  endtask

  task automatic shift_case(input string tag, input bit sel4, input int fbit,
                            input logic [31:0] a, input logic [31:0] b,
                            input int stall_from, input int stall_n,
                            input logic [31:0] exp_res, input int exp_edges, input int exp_busy);
    int e, bc;
    use4     = sel4;
    id.valid = 1'b0;
    tick();
    set_op(fbit, a, b, 1'b0);
    run_until_load(sel4, stall_from, stall_n, e, bc);
    id.valid = 1'b0;
    check({tag, " cycles"}, 32'(e), 32'(exp_edges));
    check({tag, " busy cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, " result"}, sel4 ? ex4.alu_result : ex1.alu_result, exp_res);
    $display("shift %s: cycles=%0d busy=%0d result=0x%08h", tag, e, bc,
             sel4 ? ex4.alu_result : ex1.alu_result);
  endtask

  localparam int NV = 12;
  int          v_fun [NV] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_SLT, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_OR, ALU_AND, ALU_COPY1, ALU_SLL, ALU_SRA};
  logic [31:0] v_a   [NV] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'h0000_0001, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h1234_0000,
                              32'hF0F0_F0F0, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h8000_0000};
  logic [31:0] v_b   [NV] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h0000_0001, 32'hFF00_FF00, 32'h0000_5678,
                              32'hFF00_FF00, 32'h1234_5678, 32'hFFFF_FFE0, 32'h0000_0001};
  logic [31:0] v_exp [NV] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001,
                              32'h0000_0000, 32'h0000_0000, 32'h0FF0_0FF0, 32'h1234_5678,
                              32'hF000_F000, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hC000_0000};

  initial begin
    id     = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check("reset ex1 zero", 32'(|ex1), 32'h0);
    check("reset ex4 zero", 32'(|ex4), 32'h0);
    check("reset busy1", 32'(busy1), 32'h0);

    // ADD wrap-around, loaded on the first edge after reset release
    tick();
    set_op(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    #1;
    check("add busy", 32'(busy1), 32'h0);
    rst_ni = 1'b1;
    tick();
    check("add valid", 32'(ex1.valid), 32'h1);
    check("add result", ex1.alu_result, 32'h0);
    check("add pc", ex1.pc_plus_four, 32'h0000_1004);
    check("add rd", 32'(ex1.reg_wr_addr), 32'h7);
    check("add busy after", 32'(busy1), 32'h0);
    $display("add: result=0x%08h valid=%0d", ex1.alu_result, ex1.valid);

    // Single-cycle ALU vectors
    for (int i = 0; i < NV; i++) begin
      set_op(v_fun[i], v_a[i], v_b[i], 1'b0);
      #1;
      check($sformatf("alu%0d busy", i), 32'(busy1), 32'h0);
      tick();
      check($sformatf("alu%0d valid", i), 32'(ex1.valid), 32'h1);
      check($sformatf("alu%0d result", i), ex1.alu_result, v_exp[i]);
      $display("alu vector %0d: result=0x%08h", i, ex1.alu_result);
    end

    // Invalid ID-EX loads a bubble
    id.valid = 1'b0;
    tick();
    check("bubble valid", 32'(ex1.valid), 32'h0);
    $display("bubble: valid=%0d", ex1.valid);

    // Serial shifts
    shift_case("sll31 step1", 1'b0, ALU_SLL, 32'h0000_0001, 32'd31, 99, 0, 32'h8000_0000, 31, 30);
    shift_case("sra7 step4", 1'b1, ALU_SRA, 32'h8000_0000, 32'd7, 99, 0, 32'hFF00_0000, 2, 1);
    shift_case("srl4 step4", 1'b1, ALU_SRL, 32'hF000_0000, 32'd4, 99, 0, 32'h0F00_0000, 1, 0);
    shift_case("sll5 step4", 1'b1, ALU_SLL, 32'h0000_0001, 32'd5, 99, 0, 32'h0000_0020, 2, 1);
    shift_case("srl3 hi-bits", 1'b0, ALU_SRL, 32'h8000_0000, 32'hFFFF_FFE3, 99, 0, 32'h1000_0000, 3, 2);
    shift_case("srl20 stall3", 1'b0, ALU_SRL, 32'hDEAD_BEEF, 32'd20, 5, 3, 32'h0000_0DEA, 23, 22);

    // Squash mid-shift, together with stall, on a store
    use4     = 1'b0;
    id.valid = 1'b0;
    tick();
    set_op(ALU_SRL, 32'hFFFF_0000, 32'd10, 1'b1);
    #1;
    check("squash pre busy", 32'(busy1), 32'h1);
    tick();
    tick();
    tick();
    squash = 1'b1;
    stall  = 1'b1;
    #1;
    check("squash busy", 32'(busy1), 32'h0);
    tick();
    check("squash valid", 32'(ex1.valid), 32'h0);
    check("squash wr_en", 32'(ex1.dmem_wr_en), 32'h0);
    squash   = 1'b0;
    stall    = 1'b0;
    id.valid = 1'b0;
    #1;
    check("post squash busy", 32'(busy1), 32'h0);
    tick();
    set_op(ALU_ADD, 32'd2, 32'd3, 1'b1);
    #1;
    check("post squash add busy", 32'(busy1), 32'h0);
    tick();
    check("post squash add result", ex1.alu_result, 32'd5);
    check("post squash add wr_en", 32'(ex1.dmem_wr_en), 32'h1);
    $display("squash: valid=%0d wr_en=%0d follow-up=0x%08h", ex1.valid, ex1.dmem_wr_en, ex1.alu_result);

    // Asynchronous reset in the middle of a shift
    id.valid = 1'b0;
    tick();
    set_op(ALU_SLL, 32'h0000_0001, 32'd31, 1'b0);
    repeat (5) tick();
    rst_ni = 1'b0;
    #1;
    check("midreset ex zero", 32'(|ex1), 32'h0);
    check("midreset busy", 32'(busy1), 32'h0);
    tick();
    check("in reset busy", 32'(busy1), 32'h0);
    set_op(ALU_ADD, 32'd10, 32'd20, 1'b0);
    rst_ni = 1'b1;
    tick();
    check("after reset valid", 32'(ex1.valid), 32'h1);
    check("after reset result", ex1.alu_result, 32'd30);
    check("after reset busy", 32'(busy1), 32'h0);
    $display("reset mid-shift: next result=0x%08h valid=%0d", ex1.alu_result, ex1.valid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
